// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for the forwarding scoreboard: issue info, operand lookup and results.
// master = decode/pipeline side, slave = scoreboard.
interface fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                        hold;
  logic                        flush;
  logic                        iss_valid;
  logic                        iss_we;
  logic                        iss_load;
  logic [ADDR_W-1:0]           iss_waddr;
  logic [NUM_SRC*ADDR_W-1:0]   src_addr;
  logic [NUM_SRC*DATA_W-1:0]   rf_data;
  logic [DEPTH*DATA_W-1:0]     stage_data;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   fwd_data;
  logic                        stall;
  logic [31:0]                 stall_cnt;

  modport master (
    output hold, flush, iss_valid, iss_we, iss_load, iss_waddr, src_addr, rf_data, stage_data,
    input  fwd_sel, fwd_data, stall, stall_cnt
  );

  modport slave (
    input  hold, flush, iss_valid, iss_we, iss_load, iss_waddr, src_addr, rf_data, stage_data,
    output fwd_sel, fwd_data, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shift-register forwarding/hazard scoreboard: youngest ready producer per operand, or stall.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 1
) (
  input logic             clk,
  input logic             rst_n,
  fwd_scoreboard_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             v_q;
  logic [DEPTH-1:0]             we_q;
  logic [DEPTH-1:0]             ld_q;
  logic [DEPTH-1:0][ADDR_W-1:0] waddr_q;

  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [NUM_SRC*DATA_W-1:0] fwd_data;
  logic [NUM_SRC-1:0]        pend;
  logic [ADDR_W-1:0]         src;
  logic                      found;
  logic                      stall;

  // Only the youngest match decides; an older ready entry never masks a younger unready one.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    pend     = '0;
    src      = '0;
    found    = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_data[s*DATA_W +: DATA_W] = bus.rf_data[s*DATA_W +: DATA_W];
      src   = bus.src_addr[s*ADDR_W +: ADDR_W];
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && (src != '0) && v_q[i] && we_q[i] && (waddr_q[i] == src)) begin
          found = 1'b1;
          if (i >= (ld_q[i] ? LOAD_READY : ALU_READY)) begin
            fwd_sel[s*SEL_W +: SEL_W]    = SEL_W'(i + 1);
            fwd_data[s*DATA_W +: DATA_W] = bus.stage_data[i*DATA_W +: DATA_W];
          end else begin
            pend[s] = 1'b1;
          end
        end
      end
    end
    stall = bus.iss_valid & (|pend);
  end

  assign bus.fwd_sel  = fwd_sel;
  assign bus.fwd_data = fwd_data;
  assign bus.stall    = stall;

  // A stalled or flushed issue enters stage 0 as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      we_q    <= '0;
      ld_q    <= '0;
      waddr_q <= '0;
    end else if (!bus.hold) begin
      v_q     <= {v_q[DEPTH-2:0], bus.iss_valid & ~stall & ~bus.flush};
      we_q    <= {we_q[DEPTH-2:0], bus.iss_we};
      ld_q    <= {ld_q[DEPTH-2:0], bus.iss_load};
      waddr_q <= {waddr_q[DEPTH-2:0], bus.iss_waddr};
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && !bus.hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expectations queued at drive time, popped at sample time.
module tb_fwd_scoreboard;
  localparam int NUM_SRC = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 3;

  localparam logic [31:0] RF0 = 32'hF000_000F;
  localparam logic [31:0] RF1 = 32'hF111_111F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(
    .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) bus ();

  fwd_scoreboard #(
    .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ALU_READY(0), .LOAD_READY(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    int          sel0;
    logic [31:0] d0;
    int          sel1;
    logic [31:0] d1;
    int          st;
  } exp_t;

  exp_t        q[$];
  logic [31:0] sd[DEPTH];
  int          total   = 0;
  int          passed  = 0;
  int          failed  = 0;
  int          exp_cnt = 0;

  function automatic logic [31:0] cnt_exp();
`ifdef FWD_STALL_CNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int iv, input int we, input int ld, input int wa,
                       input int s0, input int s1);
    bus.iss_valid  = 1'(iv);
    bus.iss_we     = 1'(we);
    bus.iss_load   = 1'(ld);
    bus.iss_waddr  = 5'(wa);
    bus.src_addr   = {5'(s1), 5'(s0)};
    bus.rf_data    = {RF1, RF0};
    bus.stage_data = {sd[2], sd[1], sd[0]};
  endtask

  task automatic push(input string tag, input int sel0, input logic [31:0] d0,
                      input int sel1, input logic [31:0] d1, input int st);
    exp_t e;
    e.tag  = tag;
    e.sel0 = sel0;
    e.d0   = d0;
    e.sel1 = sel1;
    e.d1   = d1;
    e.st   = st;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      total++;
      failed++;
      $error("FAIL queue_empty: observed 0 entries expected 1");
    end else begin
      e = q.pop_front();
      chk({e.tag, "/sel0"},  32'(bus.fwd_sel[1:0]), 32'(e.sel0));
      chk({e.tag, "/data0"}, bus.fwd_data[31:0],    e.d0);
      chk({e.tag, "/sel1"},  32'(bus.fwd_sel[3:2]), 32'(e.sel1));
      chk({e.tag, "/data1"}, bus.fwd_data[63:32],   e.d1);
      chk({e.tag, "/stall"}, 32'(bus.stall),        32'(e.st));
    end
  endtask

  // One clocked step: sample at negedge, then let the rising edge commit.
  task automatic cyc(input string tag, input int sel0, input logic [31:0] d0,
                     input int sel1, input logic [31:0] d1, input int st);
    push(tag, sel0, d0, sel1, d1, st);
    @(negedge clk);
    pop_check();
    if (st != 0 && !bus.hold) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    sd[0] = 32'hD000_0000;
    sd[1] = 32'hD000_0001;
    sd[2] = 32'hD000_0002;
    drive(1, 0, 0, 0, 3, 5);
    #2;
    push("reset", 0, RF0, 0, RF1, 0);
    pop_check();
    chk("reset_cnt", bus.stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(1, 1, 0, 3, 0, 0); cyc("alu_issue",   0, RF0,   0, RF1, 0);
    drive(1, 0, 0, 0, 3, 0); cyc("alu_fwd_ex",  1, sd[0], 0, RF1, 0);
    drive(1, 1, 1, 5, 3, 0); cyc("alu_fwd_mem", 2, sd[1], 0, RF1, 0);
    drive(1, 0, 0, 0, 0, 5); cyc("load_use",    0, RF0,   0, RF1, 1);
    drive(1, 0, 0, 0, 0, 5); cyc("load_fwd",    0, RF0,   2, sd[1], 0);

    drive(1, 1, 0, 4, 0, 0); cyc("r4_old",   0, RF0, 0, RF1, 0);
    drive(1, 0, 0, 0, 0, 0); cyc("r4_gap",   0, RF0, 0, RF1, 0);
    drive(1, 1, 0, 4, 0, 0); cyc("r4_young", 0, RF0, 0, RF1, 0);
    sd[0] = 32'h0000_5555;
    sd[1] = 32'h1234_5678;
    sd[2] = 32'h0000_AAAA;
    drive(1, 1, 0, 0, 4, 4); cyc("youngest_wins", 1, 32'h5555, 1, 32'h5555, 0);
    drive(1, 0, 0, 0, 0, 0); cyc("r0_never",      0, RF0,      0, RF1,      0);

    drive(1, 1, 0, 6, 0, 0); cyc("r6_alu",        0, RF0,   0, RF1, 0);
    drive(1, 1, 1, 6, 0, 0); cyc("r6_load",       0, RF0,   0, RF1, 0);
    drive(1, 0, 0, 0, 6, 0); cyc("young_unready", 0, RF0,   0, RF1, 1);
    drive(1, 0, 0, 0, 6, 0); cyc("r6_load_fwd",   2, sd[1], 0, RF1, 0);

    bus.flush = 1'b1;
    drive(1, 1, 1, 7, 0, 0); cyc("flush_load", 0, RF0, 0, RF1, 0);
    bus.flush = 1'b0;
    drive(1, 0, 0, 0, 7, 0); cyc("flushed_gone", 0, RF0, 0, RF1, 0);

    drive(1, 1, 1, 8, 0, 0); cyc("r8_load", 0, RF0, 0, RF1, 0);
    bus.hold = 1'b1;
    drive(1, 0, 0, 0, 0, 8); cyc("hold_1", 0, RF0, 0, RF1, 1);
    bus.flush = 1'b1;
    drive(1, 0, 0, 0, 0, 8); cyc("hold_2", 0, RF0, 0, RF1, 1);
    drive(0, 0, 0, 0, 0, 8); cyc("hold_3_novalid", 0, RF0, 0, RF1, 0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    drive(1, 0, 0, 0, 0, 8); cyc("after_hold", 0, RF0, 0, RF1, 1);
    drive(1, 0, 0, 0, 0, 8); cyc("r8_fwd",     0, RF0, 2, sd[1], 0);
    chk("stall_cnt", bus.stall_cnt, cnt_exp());

    drive(1, 1, 1, 9, 0, 0); cyc("r9_load", 0, RF0, 0, RF1, 0);
    drive(1, 0, 0, 0, 9, 0);
    push("r9_stall", 0, RF0, 0, RF1, 1);
    @(negedge clk);
    pop_check();
    #1;
    rst_n = 1'b0;
    push("async_rst", 0, RF0, 0, RF1, 0);
    #1;
    pop_check();
    chk("rst_cnt", bus.stall_cnt, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 9, 0); cyc("post_rst", 0, RF0, 0, RF1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
